// File: rtl/delay_sched_pkg.sv
// delay_sched_pkg: shared state type and round-robin pick helper for delay_sched
package delay_sched_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} dsched_state_t;
  localparam int RR_MAX = 32;
  localparam int RR_IW = 5;
  typedef struct packed {
    logic              valid;
    logic [RR_IW-1:0]  idx;
  } rr_pick_t;
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req, input int unsigned nreq, input int unsigned ptr);
    rr_pick_t r;
    int unsigned j;
    r = '0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      j = (ptr + k >= nreq) ? ptr + k - nreq : ptr + k;
      if (k < nreq && !r.valid && req[RR_IW'(j)]) r = '{valid: 1'b1, idx: RR_IW'(j)};
    end
    return r;
  endfunction
endpackage

// File: rtl/delay_sched_rr.sv
// delay_sched_rr: combinational round-robin picker starting the scan at ptr
module delay_sched_rr
  import delay_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    valid,
  output logic [$clog2(NREQ)-1:0] idx
);
  localparam int IW = $clog2(NREQ);
  rr_pick_t r;
  always_comb r = rr_pick(RR_MAX'(req), NREQ, 32'(ptr));
  assign valid = r.valid;
  assign idx = IW'(r.idx);
endmodule

// File: rtl/delay_sched.sv
// delay_sched: round-robin scheduler sharing one N-cycle delay timer among NREQ requesters
module delay_sched
  import delay_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int N     = 7500,
  parameter int CBITS = 13
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic            busy,
  output logic            sig,
  output logic            err
);
  localparam int IW = $clog2(NREQ);
  localparam logic [CBITS-1:0] CN = CBITS'(N);
  localparam int LIVE = NREQ * (N + 1) + 4;
  localparam int LW = $clog2(LIVE + 2);
  if (2 ** CBITS <= N || N < 1 || NREQ < 2 || NREQ > RR_MAX) begin : g_bad_params
    $error("delay_sched: need N>=1, 2**CBITS>N and 2<=NREQ<=%0d", RR_MAX);
  end
  dsched_state_t state, state_n;
  logic [CBITS-1:0] cnt, cnt_n;
  logic [IW-1:0] owner, owner_n, ptr, ptr_n, nxt, pick_ptr, win;
  logic [NREQ-1:0] gnt_n, done_n, win_oh, own_oh;
  logic win_v;
  assign nxt = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
  // in DONE the scan already starts past the finishing owner
  assign pick_ptr = (state == S_DONE) ? nxt : ptr;
  assign win_oh = NREQ'(1) << win;
  assign own_oh = NREQ'(1) << owner;
  delay_sched_rr #(.NREQ(NREQ)) u_rr (
    .req  (req),
    .ptr  (pick_ptr),
    .valid(win_v),
    .idx  (win)
  );
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    owner_n = owner;
    ptr_n = ptr;
    gnt_n = gnt;
    done_n = '0;
    case (state)
      S_IDLE: begin
        state_n = win_v ? S_RUN : S_IDLE;
        gnt_n = win_v ? win_oh : '0;
        owner_n = win_v ? win : owner;
        cnt_n = '0;
      end
      S_RUN: begin
        if (!req[owner]) begin
          state_n = S_IDLE;
          gnt_n = '0;
          cnt_n = '0;
          ptr_n = nxt;
        end else if (cnt == CN - 1'b1) begin
          state_n = S_DONE;
          cnt_n = CN;
          done_n = own_oh;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DONE: begin
        ptr_n = nxt;
        cnt_n = '0;
        state_n = win_v ? S_RUN : S_IDLE;
        gnt_n = win_v ? win_oh : '0;
        owner_n = win_v ? win : owner;
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      cnt <= '0;
      owner <= '0;
      ptr <= '0;
      gnt <= '0;
      done <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      owner <= owner_n;
      ptr <= ptr_n;
      gnt <= gnt_n;
      done <= done_n;
    end
  assign busy = state != S_IDLE;
  assign sig = cnt >= CN;
  assign err = cnt > CN;
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt));
  a_done_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(done));
  a_done_gnt: assert property (@(posedge clk) disable iff (!rst) (done & ~gnt) == '0);
  a_no_err: assert property (@(posedge clk) disable iff (!rst) !err);
  a_sig_done: assert property (@(posedge clk) disable iff (!rst) sig == (state == S_DONE));
  // liveness as a bounded wait: a held request must see its done within one full rotation
  for (genvar i = 0; i < NREQ; i++) begin : g_live
    logic [LW-1:0] wait_c;
    always_ff @(posedge clk or negedge rst)
      if (!rst) wait_c <= '0;
      else wait_c <= (!req[i] || done[i]) ? '0 : (wait_c > LW'(LIVE)) ? wait_c : wait_c + 1'b1;
    a_live: assert property (@(posedge clk) disable iff (!rst) wait_c <= LW'(LIVE));
  end
endmodule
